// File: rtl/bridge_arbiter.sv
// Two-master (CPU, DMA) to two-timer bridge: arbitrate, decode, one-cycle strobe, registered response.
// Optional macro BRIDGE_RR_EN selects round-robin arbitration instead of fixed CPU priority.
module bridge_arbiter #(
  parameter logic [31:0] T0_BASE   = 32'h0000_7F00,
  parameter logic [31:0] T1_BASE   = 32'h0000_7F10,
  parameter logic [31:0] WIN_BYTES = 32'd12,
  parameter logic [31:0] RO_OFFSET = 32'd8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CpuReq,
  input  logic        CpuWE,
  input  logic [31:0] CpuAddr,
  input  logic [31:0] CpuWD,
  output logic        CpuAck,
  output logic        CpuErr,
  output logic [31:0] CpuRD,
  input  logic        DmaReq,
  input  logic        DmaWE,
  input  logic [31:0] DmaAddr,
  input  logic [31:0] DmaWD,
  output logic        DmaAck,
  output logic        DmaErr,
  output logic [31:0] DmaRD,
  output logic [31:0] PrAddr,
  output logic [31:0] PrWD,
  output logic        PrWE,
  output logic [1:0]  PrSel,
  input  logic [31:0] PrRD0,
  input  logic [31:0] PrRD1,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_owner_dma;
  logic        r_hit0;
  logic        r_hit1;
  logic        r_err;
  logic        r_cpu_ack;
  logic        r_cpu_err;
  logic [31:0] r_cpu_rd;
  logic        r_dma_ack;
  logic        r_dma_err;
  logic [31:0] r_dma_rd;
  logic [31:0] r_pr_addr;
  logic [31:0] r_pr_wd;
  logic        r_pr_we;
  logic [1:0]  r_pr_sel;
  logic        r_busy;
`ifdef BRIDGE_RR_EN
  // 1 = CPU was granted last; reset value 0 means DMA was last, so CPU wins first.
  logic        r_last_cpu;
`endif

  logic        w_any_req;
  logic        w_grant_dma;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wd;
  logic        w_hit0;
  logic        w_hit1;
  logic [31:0] w_base;
  logic        w_err;
  logic [31:0] w_rd_sel;

  // Window test done in 33 bits so base + size can never wrap.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    logic [32:0] lo;
    logic [32:0] hi;
    logic [32:0] a;
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, WIN_BYTES};
    a  = {1'b0, addr};
    return (a >= lo) && (a < hi);
  endfunction

  // Arbitration and request mux.
  always_comb begin
    w_any_req   = CpuReq | DmaReq;
    w_grant_dma = 1'b0;
`ifdef BRIDGE_RR_EN
    if (CpuReq && DmaReq) begin
      w_grant_dma = r_last_cpu;
    end else begin
      w_grant_dma = DmaReq;
    end
`else
    if (CpuReq) begin
      w_grant_dma = 1'b0;
    end else begin
      w_grant_dma = DmaReq;
    end
`endif
    if (w_grant_dma) begin
      w_we   = DmaWE;
      w_addr = DmaAddr;
      w_wd   = DmaWD;
    end else begin
      w_we   = CpuWE;
      w_addr = CpuAddr;
      w_wd   = CpuWD;
    end
  end

  // Address decode and access checking for the winning request.
  always_comb begin
    w_hit0 = in_window(w_addr, T0_BASE);
    w_hit1 = in_window(w_addr, T1_BASE);
    if (w_hit1) begin
      w_base = T1_BASE;
    end else begin
      w_base = T0_BASE;
    end
    w_err = (w_addr[1:0] != 2'b00) || !(w_hit0 || w_hit1) ||
            (w_we && ((w_addr - w_base) == RO_OFFSET));
  end

  // Read data from the selected timer, forced to zero on an error.
  always_comb begin
    w_rd_sel = 32'h0000_0000;
    if (r_err) begin
      w_rd_sel = 32'h0000_0000;
    end else if (r_hit0) begin
      w_rd_sel = PrRD0;
    end else if (r_hit1) begin
      w_rd_sel = PrRD1;
    end else begin
      w_rd_sel = 32'h0000_0000;
    end
  end

  // Sequencer FSM with registered bus and response outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= IDLE;
      r_owner_dma <= 1'b0;
      r_hit0      <= 1'b0;
      r_hit1      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_err   <= 1'b0;
      r_cpu_rd    <= 32'h0000_0000;
      r_dma_ack   <= 1'b0;
      r_dma_err   <= 1'b0;
      r_dma_rd    <= 32'h0000_0000;
      r_pr_addr   <= 32'h0000_0000;
      r_pr_wd     <= 32'h0000_0000;
      r_pr_we     <= 1'b0;
      r_pr_sel    <= 2'b00;
      r_busy      <= 1'b0;
`ifdef BRIDGE_RR_EN
      r_last_cpu  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_cpu_ack <= 1'b0;
          r_cpu_err <= 1'b0;
          r_cpu_rd  <= 32'h0000_0000;
          r_dma_ack <= 1'b0;
          r_dma_err <= 1'b0;
          r_dma_rd  <= 32'h0000_0000;
          if (w_any_req) begin
            r_state     <= ACCESS;
            r_busy      <= 1'b1;
            r_owner_dma <= w_grant_dma;
            r_hit0      <= w_hit0;
            r_hit1      <= w_hit1;
            r_err       <= w_err;
`ifdef BRIDGE_RR_EN
            r_last_cpu  <= ~w_grant_dma;
`endif
            if (!w_err) begin
              r_pr_sel  <= {w_hit1, w_hit0};
              r_pr_we   <= w_we;
              r_pr_addr <= {w_addr[31:2], 2'b00};
              r_pr_wd   <= w_wd;
            end else begin
              r_pr_sel  <= 2'b00;
              r_pr_we   <= 1'b0;
              r_pr_addr <= 32'h0000_0000;
              r_pr_wd   <= 32'h0000_0000;
            end
          end else begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_pr_sel  <= 2'b00;
            r_pr_we   <= 1'b0;
            r_pr_addr <= 32'h0000_0000;
            r_pr_wd   <= 32'h0000_0000;
          end
        end
        ACCESS: begin
          r_state   <= RESP;
          r_busy    <= 1'b1;
          r_pr_sel  <= 2'b00;
          r_pr_we   <= 1'b0;
          r_pr_addr <= 32'h0000_0000;
          r_pr_wd   <= 32'h0000_0000;
          if (r_owner_dma) begin
            r_dma_ack <= 1'b1;
            r_dma_err <= r_err;
            r_dma_rd  <= w_rd_sel;
            r_cpu_ack <= 1'b0;
            r_cpu_err <= 1'b0;
            r_cpu_rd  <= 32'h0000_0000;
          end else begin
            r_cpu_ack <= 1'b1;
            r_cpu_err <= r_err;
            r_cpu_rd  <= w_rd_sel;
            r_dma_ack <= 1'b0;
            r_dma_err <= 1'b0;
            r_dma_rd  <= 32'h0000_0000;
          end
        end
        RESP: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_cpu_ack <= 1'b0;
          r_cpu_err <= 1'b0;
          r_cpu_rd  <= 32'h0000_0000;
          r_dma_ack <= 1'b0;
          r_dma_err <= 1'b0;
          r_dma_rd  <= 32'h0000_0000;
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_pr_sel  <= 2'b00;
          r_pr_we   <= 1'b0;
          r_pr_addr <= 32'h0000_0000;
          r_pr_wd   <= 32'h0000_0000;
          r_cpu_ack <= 1'b0;
          r_cpu_err <= 1'b0;
          r_cpu_rd  <= 32'h0000_0000;
          r_dma_ack <= 1'b0;
          r_dma_err <= 1'b0;
          r_dma_rd  <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign CpuAck = r_cpu_ack;
  assign CpuErr = r_cpu_err;
  assign CpuRD  = r_cpu_rd;
  assign DmaAck = r_dma_ack;
  assign DmaErr = r_dma_err;
  assign DmaRD  = r_dma_rd;
  assign PrAddr = r_pr_addr;
  assign PrWD   = r_pr_wd;
  assign PrWE   = r_pr_we;
  assign PrSel  = r_pr_sel;
  assign Busy   = r_busy;

endmodule
